// File: rtl/regfile_scoreboard_if.sv
// Register-file port bundle: writeback, two read ports with busy flags, and issue/scoreboard status.
// The core (decode/issue and writeback) is the master; the register file is the slave.
interface regfile_scoreboard_if #(
    parameter int N = 32,
    parameter int L = 5
);
    logic         wr_ena;
    logic [L-1:0] wr_addr;
    logic [N-1:0] wr_data;
    logic [L-1:0] rd_addr0;
    logic [L-1:0] rd_addr1;
    logic [N-1:0] rd_data0;
    logic [N-1:0] rd_data1;
    logic         rd_busy0;
    logic         rd_busy1;
    logic         issue_ena;
    logic [L-1:0] issue_addr;
    logic [L:0]   busy_count;
    logic         all_idle;

    modport master (
        output wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1, issue_ena, issue_addr,
        input  rd_data0, rd_data1, rd_busy0, rd_busy1, busy_count, all_idle
    );

    modport slave (
        input  wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1, issue_ena, issue_addr,
        output rd_data0, rd_data1, rd_busy0, rd_busy1, busy_count, all_idle
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with hardwired-zero x0, optional write-to-read bypass
// and a per-register busy scoreboard for read-after-write hazard detection.
module regfile_scoreboard #(
    parameter int N      = 32,
    parameter int L      = 5,
    parameter int BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  bus
);
    localparam int DEPTH = 2 ** L;

    // Entry 0 is never written, so both arrays hold constant zero there and synthesis prunes it.
    logic [N-1:0]     data_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [L:0]       count_q;

    logic wr_hit;
    logic issue_hit;
    logic cnt_inc;
    logic cnt_dec;

    assign wr_hit    = bus.wr_ena && (bus.wr_addr != '0);
    assign issue_hit = bus.issue_ena && (bus.issue_addr != '0);

    // A same-address issue re-marks the register, so the write's clear is cancelled.
    assign cnt_inc = issue_hit && !busy_q[bus.issue_addr];
    assign cnt_dec = wr_hit && busy_q[bus.wr_addr] &&
                     !(issue_hit && (bus.issue_addr == bus.wr_addr));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage array is reset here because the core relies on a cleared file after rst.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_hit) begin
                data_q[bus.wr_addr] <= bus.wr_data;
                busy_q[bus.wr_addr] <= 1'b0;
            end
            // Placed after the write so a same-address issue wins and busy ends at 1.
            if (issue_hit) begin
                busy_q[bus.issue_addr] <= 1'b1;
            end
            count_q <= count_q + (L + 1)'(cnt_inc) - (L + 1)'(cnt_dec);
        end
    end

    logic         fwd0;
    logic         fwd1;
    logic [N-1:0] data0;
    logic [N-1:0] data1;
    logic         busy0;
    logic         busy1;

    assign fwd0 = (BYPASS != 0) && wr_hit && (bus.wr_addr == bus.rd_addr0);
    assign fwd1 = (BYPASS != 0) && wr_hit && (bus.wr_addr == bus.rd_addr1);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        data0 = '0;
        busy0 = 1'b0;
        data1 = '0;
        busy1 = 1'b0;
        if (bus.rd_addr0 != '0) begin
            data0 = fwd0 ? bus.wr_data : data_q[bus.rd_addr0];
            busy0 = fwd0 ? 1'b0        : busy_q[bus.rd_addr0];
        end
        if (bus.rd_addr1 != '0) begin
            data1 = fwd1 ? bus.wr_data : data_q[bus.rd_addr1];
            busy1 = fwd1 ? 1'b0        : busy_q[bus.rd_addr1];
        end
    end

    assign bus.rd_data0   = data0;
    assign bus.rd_data1   = data1;
    assign bus.rd_busy0   = busy0;
    assign bus.rd_busy1   = busy1;
    assign bus.busy_count = count_q;
    assign bus.all_idle   = (count_q == '0);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a bypassed 32x32 file, a non-bypassed 32x32 file
// and a 16-bit, 8-entry file share one clock and reset.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.N(32), .L(5)) bus_a ();
    regfile_scoreboard_if #(.N(32), .L(5)) bus_b ();
    regfile_scoreboard_if #(.N(16), .L(3)) bus_c ();

    regfile_scoreboard #(.N(32), .L(5), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    regfile_scoreboard #(.N(32), .L(5), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    regfile_scoreboard #(.N(16), .L(3), .BYPASS(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
        end
    endtask

    task automatic exp_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drop write/issue strobes on the two wide files; read addresses are left alone.
    task automatic clr_ab();
        bus_a.wr_ena = 1'b0; bus_a.issue_ena = 1'b0;
        bus_b.wr_ena = 1'b0; bus_b.issue_ena = 1'b0;
    endtask

    task automatic wr_ab(input logic [4:0] addr, input logic [31:0] data);
        bus_a.wr_ena = 1'b1; bus_a.wr_addr = addr; bus_a.wr_data = data;
        bus_b.wr_ena = 1'b1; bus_b.wr_addr = addr; bus_b.wr_data = data;
    endtask

    task automatic iss_ab(input logic [4:0] addr);
        bus_a.issue_ena = 1'b1; bus_a.issue_addr = addr;
        bus_b.issue_ena = 1'b1; bus_b.issue_addr = addr;
    endtask

    task automatic rd_ab(input logic [4:0] a0, input logic [4:0] a1);
        bus_a.rd_addr0 = a0; bus_a.rd_addr1 = a1;
        bus_b.rd_addr0 = a0; bus_b.rd_addr1 = a1;
    endtask

    initial begin
        rst = 1'b1;
        clr_ab();
        wr_ab(5'd0, 32'h0); clr_ab();
        iss_ab(5'd0);       clr_ab();
        rd_ab(5'd0, 5'd0);
        bus_c.wr_ena = 1'b0; bus_c.wr_addr = '0; bus_c.wr_data = '0;
        bus_c.issue_ena = 1'b0; bus_c.issue_addr = '0;
        bus_c.rd_addr0 = '0; bus_c.rd_addr1 = '0;
        #12 rst = 1'b0;
        #1;

        // Reset state.
        rd_ab(5'd5, 5'd7);
        #1;
        exp_push("por_data0", 32'h0);        observe(bus_a.rd_data0);
        exp_push("por_count", 32'h0);        observe(32'(bus_a.busy_count));
        exp_push("por_idle", 32'h1);         observe(32'(bus_a.all_idle));
        exp_push("por_count_c", 32'h0);      observe(32'(bus_c.busy_count));

        // Write x5, issue x7, then asynchronous reset mid-cycle.
        step();
        wr_ab(5'd5, 32'h1234); iss_ab(5'd7);
        step();
        clr_ab();
        #1;
        exp_push("pre_rst_data0", 32'h1234); observe(bus_a.rd_data0);
        exp_push("pre_rst_busy1", 32'h1);    observe(32'(bus_a.rd_busy1));
        exp_push("pre_rst_count", 32'h1);    observe(32'(bus_a.busy_count));
        #2 rst = 1'b1;
        #1;
        exp_push("rst_data0", 32'h0);        observe(bus_a.rd_data0);
        exp_push("rst_busy1", 32'h0);        observe(32'(bus_a.rd_busy1));
        exp_push("rst_count", 32'h0);        observe(32'(bus_a.busy_count));
        exp_push("rst_idle", 32'h1);         observe(32'(bus_a.all_idle));
        #2 rst = 1'b0;
        step();

        // x0 is hardwired; x31 reads back on both ports; issue to x0 is ignored.
        wr_ab(5'd0, 32'hDEADBEEF);
        step();
        wr_ab(5'd31, 32'hCAFEF00D); iss_ab(5'd0);
        step();
        clr_ab();
        rd_ab(5'd0, 5'd0);
        #1;
        exp_push("x0_data0", 32'h0);         observe(bus_a.rd_data0);
        exp_push("x0_busy1", 32'h0);         observe(32'(bus_a.rd_busy1));
        exp_push("x0_issue_count", 32'h0);   observe(32'(bus_a.busy_count));
        rd_ab(5'd31, 5'd31);
        #1;
        exp_push("x31_data0", 32'hCAFEF00D); observe(bus_a.rd_data0);
        exp_push("x31_data1", 32'hCAFEF00D); observe(bus_a.rd_data1);

        // Bypass versus no bypass.
        step();
        wr_ab(5'd3, 32'h11111111);
        step();
        wr_ab(5'd3, 32'hA5A5A5A5);
        rd_ab(5'd3, 5'd0);
        #1;
        exp_push("byp_on_data0", 32'hA5A5A5A5);  observe(bus_a.rd_data0);
        exp_push("byp_off_data0", 32'h11111111); observe(bus_b.rd_data0);
        step();
        clr_ab();
        #1;
        exp_push("byp_off_after", 32'hA5A5A5A5); observe(bus_b.rd_data0);

        // Scoreboard: issue x4, x9, x4, then write x4 and x9.
        iss_ab(5'd4);
        step(); clr_ab(); #1;
        exp_push("sb_count_1", 32'd1);       observe(32'(bus_a.busy_count));
        iss_ab(5'd9);
        step(); clr_ab(); #1;
        exp_push("sb_count_2", 32'd2);       observe(32'(bus_a.busy_count));
        iss_ab(5'd4);
        step(); clr_ab();
        rd_ab(5'd4, 5'd9);
        #1;
        exp_push("sb_count_re", 32'd2);      observe(32'(bus_a.busy_count));
        exp_push("sb_busy4", 32'h1);         observe(32'(bus_a.rd_busy0));
        exp_push("sb_busy9", 32'h1);         observe(32'(bus_a.rd_busy1));
        wr_ab(5'd4, 32'h44);
        #1;
        exp_push("sb_byp_busy4", 32'h0);     observe(32'(bus_a.rd_busy0));
        exp_push("sb_nobyp_busy4", 32'h1);   observe(32'(bus_b.rd_busy0));
        step(); clr_ab(); #1;
        exp_push("sb_count_wr", 32'd1);      observe(32'(bus_a.busy_count));
        exp_push("sb_busy4_wr", 32'h0);      observe(32'(bus_a.rd_busy0));
        exp_push("sb_busy9_wr", 32'h1);      observe(32'(bus_a.rd_busy1));
        exp_push("sb_count_wr_b", 32'd1);    observe(32'(bus_b.busy_count));
        wr_ab(5'd9, 32'h99);
        step(); clr_ab(); #1;
        exp_push("sb_count_0", 32'd0);       observe(32'(bus_a.busy_count));
        exp_push("sb_idle", 32'h1);          observe(32'(bus_a.all_idle));

        // Same-address write and issue, then split write/issue.
        iss_ab(5'd6);
        step(); clr_ab(); #1;
        exp_push("same_pre_count", 32'd1);   observe(32'(bus_a.busy_count));
        wr_ab(5'd6, 32'h66); iss_ab(5'd6);
        step(); clr_ab();
        rd_ab(5'd6, 5'd8);
        #1;
        exp_push("same_data", 32'h66);       observe(bus_a.rd_data0);
        exp_push("same_busy", 32'h1);        observe(32'(bus_a.rd_busy0));
        exp_push("same_count", 32'd1);       observe(32'(bus_a.busy_count));
        wr_ab(5'd6, 32'h67); iss_ab(5'd8);
        step(); clr_ab(); #1;
        exp_push("split_count", 32'd1);      observe(32'(bus_a.busy_count));
        exp_push("split_busy6", 32'h0);      observe(32'(bus_a.rd_busy0));
        exp_push("split_busy8", 32'h1);      observe(32'(bus_a.rd_busy1));
        exp_push("split_data6", 32'h67);     observe(bus_a.rd_data0);
        wr_ab(5'd8, 32'h88);
        step(); clr_ab(); #1;
        exp_push("split_drain", 32'd0);      observe(32'(bus_a.busy_count));

        // Narrow configuration: fill and drain the whole scoreboard.
        for (int i = 1; i < 8; i++) begin
            bus_c.issue_ena = 1'b1; bus_c.issue_addr = 3'(i);
            step();
        end
        bus_c.issue_ena = 1'b0;
        bus_c.rd_addr0 = 3'd7;
        #1;
        exp_push("c_full_count", 32'd7);     observe(32'(bus_c.busy_count));
        exp_push("c_full_idle", 32'h0);      observe(32'(bus_c.all_idle));
        exp_push("c_busy7", 32'h1);          observe(32'(bus_c.rd_busy0));
        for (int i = 1; i < 8; i++) begin
            bus_c.wr_ena = 1'b1; bus_c.wr_addr = 3'(i); bus_c.wr_data = 16'(16'h1000 + i);
            step();
        end
        bus_c.wr_ena = 1'b0;
        #1;
        exp_push("c_empty_count", 32'd0);    observe(32'(bus_c.busy_count));
        exp_push("c_empty_idle", 32'h1);     observe(32'(bus_c.all_idle));
        exp_push("c_data7", 32'h1007);       observe(32'(bus_c.rd_data0));
        exp_push("c_x0", 32'h0);             observe(32'(bus_c.rd_data1));

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
